// File: rtl/decode_issue_ctrl.sv
// Fetch-to-Decode issue controller: in-order instruction queue, one issue per cycle,
// issue hold while a branch is outstanding, and queue clear on mispredict or flush.
module decode_issue_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSN_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-3:0] fetch_addr,
  input  logic [INSN_WIDTH-1:0] fetch_insn,
  output logic                  dec_valid,
  output logic [ADDR_WIDTH-3:0] dec_addr,
  output logic [INSN_WIDTH-1:0] dec_insn,
  input  logic                  dec_stall,
  input  logic                  br_resolve_valid,
  input  logic                  br_redirect,
  input  logic [ADDR_WIDTH-3:0] br_target,
  input  logic                  flush,
  output logic                  fetch_redirect_valid,
  output logic [ADDR_WIDTH-3:0] fetch_redirect_addr,
  output logic                  busy_br_wait
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-3:0] addr_q [QUEUE_DEPTH];
  logic [INSN_WIDTH-1:0] insn_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;

  logic mispredict;
  logic redirect_take;
  logic clear;
  logic push;
  logic pop;
  logic head_branch;

  // Same predicate as InsnDecodePkg::insn_is_branch: conditional branches, JAL and JALR
  // are all identified by the major opcode in the low 7 bits.
  function automatic logic insn_is_branch(input logic [6:0] opcode);
    return (opcode == 7'b1100011) || (opcode == 7'b1101111) || (opcode == 7'b1100111);
  endfunction

  assign mispredict    = br_resolve_valid && br_redirect;
  assign fetch_ready   = (count != FULL_CNT) && !flush && !mispredict;
  assign push          = fetch_valid && fetch_ready;
  assign pop           = (state == RUN) && (count != '0) && !dec_stall && !flush;
  assign head_branch   = insn_is_branch(insn_q[rd_ptr][6:0]);
  // A resolve outside BR_WAIT is ignored, so only a waiting branch can redirect.
  assign redirect_take = (state == BR_WAIT) && mispredict;
  assign clear         = flush || redirect_take;
  assign busy_br_wait  = (state == BR_WAIT);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (pop && head_branch) state_nxt = BR_WAIT;
      BR_WAIT: if (br_resolve_valid)   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (flush) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= fetch_addr;
      insn_q[wr_ptr] <= fetch_insn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_addr  <= '0;
      dec_insn  <= '0;
    end else if (pop) begin
      dec_valid <= 1'b1;
      dec_addr  <= addr_q[rd_ptr];
      dec_insn  <= insn_q[rd_ptr];
    end else begin
      dec_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_redirect_valid <= 1'b0;
      fetch_redirect_addr  <= '0;
    end else begin
      fetch_redirect_valid <= redirect_take;
      if (redirect_take) fetch_redirect_addr <= br_target;
    end
  end

  a_resolve_only_in_br_wait: assert property (
    @(posedge clk) disable iff (rst) br_resolve_valid |-> (state == BR_WAIT)
  ) else $error("br_resolve_valid asserted with no branch outstanding");

  a_count_in_range: assert property (
    @(posedge clk) disable iff (rst) count <= FULL_CNT
  ) else $error("queue count out of range");

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the issue rules.
module tb_decode_issue_ctrl;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [AW-3:0] fetch_addr;
  logic [IW-1:0] fetch_insn;
  logic          dec_valid;
  logic [AW-3:0] dec_addr;
  logic [IW-1:0] dec_insn;
  logic          dec_stall;
  logic          br_resolve_valid;
  logic          br_redirect;
  logic [AW-3:0] br_target;
  logic          flush;
  logic          fetch_redirect_valid;
  logic [AW-3:0] fetch_redirect_addr;
  logic          busy_br_wait;

  decode_issue_ctrl #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_insn(fetch_insn),
    .dec_valid(dec_valid), .dec_addr(dec_addr), .dec_insn(dec_insn),
    .dec_stall(dec_stall),
    .br_resolve_valid(br_resolve_valid), .br_redirect(br_redirect), .br_target(br_target),
    .flush(flush),
    .fetch_redirect_valid(fetch_redirect_valid), .fetch_redirect_addr(fetch_redirect_addr),
    .busy_br_wait(busy_br_wait)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-3:0] a;
    logic [IW-1:0] i;
  } ent_t;

  ent_t          q[$];
  bit            m_wait;
  logic          m_dv;
  logic [AW-3:0] m_da;
  logic [IW-1:0] m_di;
  logic          m_rv;
  logic [AW-3:0] m_ra;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_br(input logic [IW-1:0] insn);
    return (insn[6:0] == 7'h63) || (insn[6:0] == 7'h6F) || (insn[6:0] == 7'h67);
  endfunction

  function automatic logic [IW-1:0] nb_insn(input int k);
    logic [IW-1:0] v;
    v = IW'(k);
    return {v[24:0], 7'b0010011};
  endfunction

  function automatic logic [IW-1:0] br_insn(input int k);
    logic [IW-1:0] v;
    v = IW'(k);
    return {v[24:0], 7'b1100011};
  endfunction

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic fv, input logic [AW-3:0] fa, input logic [IW-1:0] fi,
                       input logic st, input logic rv, input logic rd,
                       input logic [AW-3:0] tg, input logic fl, input logic rs);
    bit   exp_ready, was_wait, do_red;
    ent_t e;
    if (rv && !m_wait) rv = 1'b0;
    rst = rs; fetch_valid = fv; fetch_addr = fa; fetch_insn = fi; dec_stall = st;
    br_resolve_valid = rv; br_redirect = rd; br_target = tg; flush = fl;
    #1;
    exp_ready = (q.size() != QD) && !fl && !(rv && rd);
    if (!rs) begin
      chk("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
      chk("busy_br_wait", 64'(busy_br_wait), 64'(m_wait));
    end
    if (rs) begin
      q.delete(); m_wait = 0; m_dv = 0; m_da = '0; m_di = '0; m_rv = 0; m_ra = '0;
    end else begin
      was_wait = m_wait;
      do_red   = was_wait && rv && rd;
      if (fl) begin
        q.delete(); m_wait = 0; m_dv = 0;
      end else begin
        if (!m_wait && q.size() > 0 && !st) begin
          e = q.pop_front();
          m_dv = 1; m_da = e.a; m_di = e.i;
          if (is_br(e.i)) m_wait = 1;
        end else m_dv = 0;
        if (fv && exp_ready) q.push_back('{a: fa, i: fi});
        if (was_wait && rv) begin
          m_wait = 0;
          if (rd) q.delete();
        end
      end
      m_rv = do_red;
      if (do_red) m_ra = tg;
    end
    @(posedge clk);
    @(negedge clk);
    chk("dec_valid", 64'(dec_valid), 64'(m_dv));
    chk("dec_addr", 64'(dec_addr), 64'(m_da));
    chk("dec_insn", 64'(dec_insn), 64'(m_di));
    chk("redirect_valid", 64'(fetch_redirect_valid), 64'(m_rv));
    chk("redirect_addr", 64'(fetch_redirect_addr), 64'(m_ra));
  endtask

  task automatic push(input logic [AW-3:0] a, input logic [IW-1:0] i, input logic st);
    cycle(1'b1, a, i, st, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic st);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, st, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [AW-3:0] nxt;
    logic [IW-1:0] ins;
    logic          fv, st, fl, rs, rv, rd;
    m_wait = 0; m_dv = 0; m_da = '0; m_di = '0; m_rv = 0; m_ra = '0;

    // Reset
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Basic issue
    push(30'h10, nb_insn(1), 1'b0);
    push(30'h11, nb_insn(2), 1'b0);
    push(30'h12, nb_insn(3), 1'b0);
    idle(3, 1'b0);

    // Full, backpressure and pointer wrap
    for (int k = 0; k < 4; k++) push(30'h60 + 30'(k), nb_insn(16 + k), 1'b1);
    push(30'h64, nb_insn(20), 1'b1);
    for (int k = 0; k < 6; k++) push(30'h64 + 30'(k), nb_insn(20 + k), 1'b0);
    idle(6, 1'b0);

    // Branch without redirect
    push(30'h20, br_insn(32), 1'b0);
    push(30'h21, nb_insn(33), 1'b0);
    idle(5, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Branch with redirect
    push(30'h30, br_insn(48), 1'b0);
    push(30'h31, nb_insn(49), 1'b0);
    push(30'h32, nb_insn(50), 1'b0);
    cycle(1'b1, 30'h33, nb_insn(51), 1'b0, 1'b1, 1'b1, 30'h80, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Flush in BR_WAIT with a push in the flush cycle
    push(30'h40, br_insn(64), 1'b0);
    push(30'h41, nb_insn(65), 1'b0);
    push(30'h42, nb_insn(66), 1'b0);
    push(30'h43, nb_insn(67), 1'b0);
    cycle(1'b1, 30'h44, nb_insn(68), 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Flush together with a redirecting resolve
    push(30'h48, br_insn(72), 1'b0);
    push(30'h49, nb_insn(73), 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 30'h90, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Mid-operation reset with two queued entries and dec_valid high
    for (int k = 0; k < 4; k++) push(30'h50 + 30'(k), nb_insn(80 + k), 1'b1);
    idle(2, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Random traffic
    nxt = 30'h100;
    for (int n = 0; n < 3000; n++) begin
      fv  = ($urandom_range(0, 99) < 70);
      st  = ($urandom_range(0, 99) < 25);
      fl  = ($urandom_range(0, 99) < 3);
      rs  = ($urandom_range(0, 299) == 0);
      rv  = m_wait && ($urandom_range(0, 99) < 30);
      rd  = 1'($urandom_range(0, 1));
      ins = ($urandom_range(0, 99) < 25) ? br_insn(int'($urandom)) : nb_insn(int'($urandom));
      cycle(fv, nxt, ins, st, rv, rd, AW-2'($urandom), fl, rs);
      if (fv) nxt = nxt + 30'd1;
    end
    idle(8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Sequences instructions from fetch into the Decode stage.
- Buffers fetched instructions in a small in-order queue.
- Issues them one per cycle as registered valid/addr/insn to Decode.
- Holds issue after a branch until the branch resolves.
- On a mispredict redirect or an external flush, empties the queue and redirects fetch.

Parameters:
ADDR_WIDTH, 32, byte-address width; addresses are carried as [ADDR_WIDTH-1:2], 4-byte aligned.
INSN_WIDTH, 32, instruction width in bits.
QUEUE_DEPTH, 4, entries in the instruction queue; power of 2, minimum 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
fetch_valid  in  1  fetch offers an instruction
fetch_ready  out  1  queue accepts; high when queue not full and no flush/redirect this cycle
fetch_addr  in  ADDR_WIDTH-2  word address of offered instruction
fetch_insn  in  INSN_WIDTH  offered instruction
dec_valid  out  1  registered; instruction valid into Decode
dec_addr  out  ADDR_WIDTH-2  registered; word address into Decode
dec_insn  out  INSN_WIDTH  registered; instruction into Decode
dec_stall  in  1  downstream backpressure; no issue this cycle
br_resolve_valid  in  1  outstanding branch resolved this cycle
br_redirect  in  1  with resolve: mispredicted, redirect required
br_target  in  ADDR_WIDTH-2  with resolve+redirect: new fetch word address
flush  in  1  external flush (exception/trap)
fetch_redirect_valid  out  1  registered, 1-cycle pulse: fetch must restart at fetch_redirect_addr
fetch_redirect_addr  out  ADDR_WIDTH-2  registered redirect target
busy_br_wait  out  1  high while state is BR_WAIT

Behaviour:
- Reset:
  - Queue empty (rd/wr pointers and count = 0); state RUN.
  - dec_valid=0, fetch_redirect_valid=0, dec_addr/dec_insn/fetch_redirect_addr=0.
  - Reset asserted mid-operation discards all queued and outstanding state.
- Queue push:
  - Push on fetch_valid && fetch_ready.
  - fetch_ready = (count != QUEUE_DEPTH) && !flush && !(br_resolve_valid && br_redirect). It is computed from registered count; there is no full-bypass.
  - Pointers wrap modulo QUEUE_DEPTH. Count is log2(QUEUE_DEPTH)+1 bits.
- Issue (pop):
  - Issue when state==RUN && count!=0 && !dec_stall && !flush.
  - On the next edge: dec_valid<=1, dec_addr/dec_insn<=queue head, head popped.
  - Otherwise dec_valid<=0; dec_addr/dec_insn hold.
  - Latency: an instruction pushed at edge N is issued at the earliest at edge N+1 (dec_valid high in cycle N+1) if the queue was empty.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into a full queue is impossible (fetch_ready=0).
- Branch detection: InsnDecodePkg::insn_is_branch(head insn) is evaluated at issue. If the issued instruction is a branch, state RUN->BR_WAIT on the same edge.
- State machine:
  - RUN: issue as above.
  - BR_WAIT: no issue; pushes continue until full; busy_br_wait=1.
  - BR_WAIT & br_resolve_valid & !br_redirect: ->RUN; issue resumes the next cycle.
  - BR_WAIT & br_resolve_valid & br_redirect: ->RUN; queue cleared; fetch_redirect_valid<=1; fetch_redirect_addr<=br_target.
  - br_resolve_valid in RUN: ignored, and flagged by assertion.
- flush:
  - Highest priority, in any state: queue cleared, state->RUN, dec_valid<=0, no push/pop that cycle.
  - fetch_redirect_valid is not driven by flush; the flush source redirects fetch.
  - flush together with a redirecting resolve: the flush effects apply, and fetch_redirect_valid is still pulsed with br_target.
- fetch_redirect_valid is a single-cycle pulse and deasserts the following cycle.

Test Plan:
- Basic issue: after reset, push 3 non-branch insns at addr 0x10,0x11,0x12 on consecutive cycles -> dec_valid high for 3 consecutive cycles starting 1 cycle after the first push, dec_addr 0x10,0x11,0x12 in order, count back to 0.
- Full/backpressure: hold dec_stall=1, push 4 insns -> fetch_ready=0 after the 4th; release stall while pushing -> one issue per cycle, fetch_ready returns 1, no loss or duplication across pointer wrap.
- Branch no-redirect: queue [branch@0x20, insn@0x21] -> branch issued, busy_br_wait=1, 0x21 not issued for 5 cycles; resolve with br_redirect=0 -> 0x21 issued the next cycle.
- Branch redirect: queue [branch@0x30, 0x31, 0x32]; resolve with redirect, br_target=0x80 -> queue empty, fetch_redirect_valid one cycle with addr 0x80, 0x31/0x32 never issued, fetch_ready=0 in the resolve cycle.
- Flush: queue 3 entries in BR_WAIT, assert flush -> next cycle count=0, state RUN, dec_valid=0; a push in the flush cycle is dropped.
- Mid-op reset: assert rst with 2 queued entries and dec_valid=1 -> next cycle dec_valid=0, fetch_ready=1, all outputs at reset values.
